// File: rtl/axis_dm_s2mm_lite_if.sv
// Bundle of every signal of the lite stream-to-memory data mover except clk/rst.
// The slave modport is the mover itself; the master modport is the command/data source and memory sink.
interface axis_dm_s2mm_lite_if #(
    parameter int C_M_AXIS_CMD_DATA_WIDTH = 73,
    parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH      = 32,
    parameter int C_S_AXI_ADDR_WIDTH      = 32
);
    // command stream
    logic                               S_AXIS_CMD_TVALID;
    logic                               S_AXIS_CMD_TREADY;
    logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA;
    // status stream
    logic                               M_AXIS_STS_TVALID;
    logic                               M_AXIS_STS_TREADY;
    logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA;
    // data stream
    logic                               S_AXIS_DATA_TVALID;
    logic                               S_AXIS_DATA_TREADY;
    logic                               S_AXIS_DATA_TLAST;
    logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXIS_DATA_TDATA;
    // memory write port
    logic                               mem_wr_en;
    logic                               mem_wr_ready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]      mem_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]      mem_wr_data;
    // observability
    logic [63:0]                        debug;

    modport slave (
        input  S_AXIS_CMD_TVALID,
        input  S_AXIS_CMD_TDATA,
        output S_AXIS_CMD_TREADY,
        output M_AXIS_STS_TVALID,
        output M_AXIS_STS_TDATA,
        input  M_AXIS_STS_TREADY,
        input  S_AXIS_DATA_TVALID,
        input  S_AXIS_DATA_TLAST,
        input  S_AXIS_DATA_TDATA,
        output S_AXIS_DATA_TREADY,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_ready,
        output debug
    );

    modport master (
        output S_AXIS_CMD_TVALID,
        output S_AXIS_CMD_TDATA,
        input  S_AXIS_CMD_TREADY,
        input  M_AXIS_STS_TVALID,
        input  M_AXIS_STS_TDATA,
        output M_AXIS_STS_TREADY,
        output S_AXIS_DATA_TVALID,
        output S_AXIS_DATA_TLAST,
        output S_AXIS_DATA_TDATA,
        input  S_AXIS_DATA_TREADY,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_ready,
        input  debug
    );
endinterface

// File: rtl/axis_dm_s2mm_lite.sv
// Lite S2MM data mover: takes one command (BTT/EOF/ADDR/TAG), streams BTT/4 words to a memory
// write port at zero latency and returns one status byte. Ports: clk, rst, bus (slave modport).
module axis_dm_s2mm_lite #(
    parameter int C_M_AXIS_CMD_DATA_WIDTH = 73,
    parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH      = 32,
    parameter int C_S_AXI_ADDR_WIDTH      = 32
) (
    input logic                 clk,
    input logic                 rst,
    axis_dm_s2mm_lite_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_STS  = 2'd2;

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [20:0]   rem_q, rem_d;
    logic [3:0]    tag_q, tag_d;
    logic          eof_q, eof_d;
    logic          interr_q, interr_d;
    logic [15:0]   done_cnt_q, done_cnt_d;
    // Holds command ready low until the first clock edge after reset release.
    logic          live_q;

    // Command field decode
    logic [22:0]   cmd_btt;
    logic          cmd_eof;
    logic [31:0]   cmd_addr;
    logic [3:0]    cmd_tag;
    logic          cmd_bad;

    assign cmd_btt  = bus.S_AXIS_CMD_TDATA[22:0];
    assign cmd_eof  = bus.S_AXIS_CMD_TDATA[30];
    assign cmd_addr = bus.S_AXIS_CMD_TDATA[63:32];
    assign cmd_tag  = bus.S_AXIS_CMD_TDATA[67:64];
    assign cmd_bad  = (cmd_btt == 23'd0) || (cmd_btt[1:0] != 2'b00);

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{bus.S_AXIS_CMD_TDATA[C_M_AXIS_CMD_DATA_WIDTH-1:68],
                               bus.S_AXIS_CMD_TDATA[31],
                               bus.S_AXIS_CMD_TDATA[29:23]};

    // Handshakes
    logic cmd_ready;
    logic cmd_hs;
    logic data_ready;
    logic data_hs;
    logic sts_hs;

    assign cmd_ready  = live_q && (state_q == ST_IDLE);
    assign cmd_hs     = cmd_ready && bus.S_AXIS_CMD_TVALID;
    assign data_ready = (state_q == ST_XFER) && bus.mem_wr_ready;
    assign data_hs    = data_ready && bus.S_AXIS_DATA_TVALID;
    assign sts_hs     = (state_q == ST_STS) && bus.M_AXIS_STS_TREADY;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        eof_d      = eof_q;
        interr_d   = interr_q;
        done_cnt_d = done_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    tag_d    = cmd_tag;
                    eof_d    = cmd_eof;
                    addr_d   = AW'(cmd_addr);
                    rem_d    = cmd_btt[22:2];
                    interr_d = cmd_bad;
                    state_d  = cmd_bad ? ST_STS : ST_XFER;
                end
            end
            ST_XFER: begin
                if (data_hs) begin
                    addr_d = addr_q + AW'(4);
                    rem_d  = rem_q - 21'd1;
                    if (rem_q == 21'd1) begin
                        // Final beat: TLAST must agree with the EOF request.
                        interr_d = eof_q ^ bus.S_AXIS_DATA_TLAST;
                        state_d  = ST_STS;
                    end else if (bus.S_AXIS_DATA_TLAST) begin
                        // Packet ended before the requested byte count.
                        interr_d = 1'b1;
                        state_d  = ST_STS;
                    end
                end
            end
            ST_STS: begin
                if (sts_hs) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tag_q      <= '0;
            eof_q      <= 1'b0;
            interr_q   <= 1'b0;
            done_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tag_q      <= tag_d;
            eof_q      <= eof_d;
            interr_q   <= interr_d;
            done_cnt_q <= done_cnt_d;
            live_q     <= 1'b1;
        end
    end

    // Status byte {OKAY, SLVERR, DECERR, INTERR, TAG}; forced to zero outside STS so it
    // reads 0 in reset and is held stable by the registers while STS waits.
    logic [7:0] sts_byte;
    assign sts_byte = (state_q == ST_STS) ? {~interr_q, 2'b00, interr_q, tag_q} : 8'h00;

    // Outputs
    assign bus.S_AXIS_CMD_TREADY  = cmd_ready;
    assign bus.M_AXIS_STS_TVALID  = (state_q == ST_STS);
    assign bus.M_AXIS_STS_TDATA   = C_M_AXIS_STS_DATA_WIDTH'(sts_byte);
    assign bus.S_AXIS_DATA_TREADY = data_ready;
    assign bus.mem_wr_en          = data_hs;
    assign bus.mem_wr_addr        = addr_q;
    assign bus.mem_wr_data        = bus.S_AXIS_DATA_TDATA;
    assign bus.debug              = {23'd0, done_cnt_q, 2'b00, rem_q, state_q};

endmodule

// File: tb/tb_axis_dm_s2mm_lite.sv
// Directed bench for axis_dm_s2mm_lite: vector table of commands with expected writes and
// status, plus hand-written reset sequences.
module tb_axis_dm_s2mm_lite;

    logic clk;
    logic rst;

    axis_dm_s2mm_lite_if #(
        .C_M_AXIS_CMD_DATA_WIDTH(73),
        .C_M_AXIS_STS_DATA_WIDTH(8),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32)
    ) bus ();

    axis_dm_s2mm_lite #(
        .C_M_AXIS_CMD_DATA_WIDTH(73),
        .C_M_AXIS_STS_DATA_WIDTH(8),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    typedef struct {
        logic [31:0] addr;
        logic [22:0] btt;
        bit          eof;
        logic [3:0]  tag;
        int          nbeats;
        int          tlast_beat;
        bit          bp;
        bit          hold;
        int          sts_delay;
        int          exp_writes;
        logic [7:0]  exp_sts;
        logic [22:0] exp_rem;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [3:0] tag, input int i);
        pat = 32'hD000_0000 | ({28'd0, tag} << 16) | 32'(i);
    endfunction

    // Write monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            wq_addr.push_back(bus.mem_wr_addr);
            wq_data.push_back(bus.mem_wr_data);
            if (bus.debug[1:0] !== 2'd1 || bus.S_AXIS_DATA_TREADY !== 1'b1) begin
                errors++;
                $display("FAIL wr_outside_xfer: state %0d tready %b", bus.debug[1:0],
                         bus.S_AXIS_DATA_TREADY);
            end
        end
    end

    task automatic wait_cmd_ready();
        int cyc = 0;
        while (bus.S_AXIS_CMD_TREADY !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("cmd_ready_wait", {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd1);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [22:0] btt,
                            input bit eof, input logic [3:0] tag);
        logic [72:0] d;
        d = '0;
        d[22:0]  = btt;
        d[30]    = eof;
        d[63:32] = addr;
        d[67:64] = tag;
        // junk in ignored fields
        d[72:68] = 5'h1f;
        d[31]    = 1'b1;
        d[25]    = 1'b1;
        bus.S_AXIS_CMD_TVALID = 1'b1;
        bus.S_AXIS_CMD_TDATA  = d;
        @(posedge clk);
        #1;
        bus.S_AXIS_CMD_TVALID = 1'b0;
        bus.S_AXIS_CMD_TDATA  = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int beat;
        int cyc;
        bit hs;
        logic [7:0] got;
        wq_addr.delete();
        wq_data.delete();
        wait_cmd_ready();
        send_cmd(v.addr, v.btt, v.eof, v.tag);
        beat = 0;
        cyc  = 0;
        while (beat < v.nbeats && cyc < 60) begin
            bus.S_AXIS_DATA_TVALID = 1'b1;
            bus.S_AXIS_DATA_TDATA  = pat(v.tag, beat);
            bus.S_AXIS_DATA_TLAST  = (beat == v.tlast_beat);
            bus.mem_wr_ready       = v.bp ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            hs = bus.S_AXIS_DATA_TVALID && bus.S_AXIS_DATA_TREADY;
            @(posedge clk);
            #1;
            if (hs) beat++;
            cyc++;
        end
        chk({nm, "_beats_taken"}, 64'(beat), 64'(v.nbeats));
        bus.S_AXIS_DATA_TVALID = v.hold;
        bus.S_AXIS_DATA_TDATA  = pat(v.tag, 0);
        bus.S_AXIS_DATA_TLAST  = 1'b0;
        bus.mem_wr_ready       = 1'b1;
        cyc = 0;
        while (bus.M_AXIS_STS_TVALID !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_sts_valid"}, {63'd0, bus.M_AXIS_STS_TVALID}, 64'd1);
        got = bus.M_AXIS_STS_TDATA;
        chk({nm, "_sts"}, {56'd0, got}, {56'd0, v.exp_sts});
        chk({nm, "_sts_state"}, {62'd0, bus.debug[1:0]}, 64'd2);
        chk({nm, "_rem"}, {41'd0, bus.debug[24:2]}, {41'd0, v.exp_rem});
        chk({nm, "_data_stall"}, {63'd0, bus.S_AXIS_DATA_TREADY}, 64'd0);
        chk({nm, "_cmd_blocked"}, {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd0);
        for (int i = 0; i < v.sts_delay; i++) begin
            @(posedge clk);
            #1;
            chk({nm, "_sts_hold_v"}, {63'd0, bus.M_AXIS_STS_TVALID}, 64'd1);
            chk({nm, "_sts_hold_d"}, {56'd0, bus.M_AXIS_STS_TDATA}, {56'd0, got});
        end
        bus.M_AXIS_STS_TREADY = 1'b1;
        @(posedge clk);
        #1;
        bus.M_AXIS_STS_TREADY  = 1'b0;
        bus.S_AXIS_DATA_TVALID = 1'b0;
        cnt_model++;
        chk({nm, "_sts_drop"}, {63'd0, bus.M_AXIS_STS_TVALID}, 64'd0);
        chk({nm, "_next_cmd_ready"}, {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd1);
        chk({nm, "_done_cnt"}, {48'd0, bus.debug[40:25]}, 64'(cnt_model[15:0]));
        chk({nm, "_nwrites"}, 64'(wq_addr.size()), 64'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < wq_addr.size(); i++) begin
            chk({nm, "_wr_addr"}, {32'd0, wq_addr[i]}, {32'd0, v.addr + 32'(4 * i)});
            chk({nm, "_wr_data"}, {32'd0, wq_data[i]}, {32'd0, pat(v.tag, i)});
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_cmd_rdy"}, {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd0);
        chk({nm, "_sts_v"}, {63'd0, bus.M_AXIS_STS_TVALID}, 64'd0);
        chk({nm, "_data_rdy"}, {63'd0, bus.S_AXIS_DATA_TREADY}, 64'd0);
        chk({nm, "_wr_en"}, {63'd0, bus.mem_wr_en}, 64'd0);
        chk({nm, "_sts_d"}, {56'd0, bus.M_AXIS_STS_TDATA}, 64'd0);
        chk({nm, "_debug"}, bus.debug, 64'd0);
    endtask

    initial begin
        vec_t rv;
        int nw;

        //          addr           btt  eof tag nb tl bp hold dly wr sts    rem
        vecs[0] = '{32'h0000_1000, 23'd16, 1, 4'h5, 4, 3, 0, 0, 0, 4, 8'h85, 23'd0};
        vecs[1] = '{32'h0000_1000, 23'd16, 1, 4'h5, 4, 3, 1, 0, 0, 4, 8'h85, 23'd0};
        vecs[2] = '{32'h0000_2000, 23'd32, 1, 4'h3, 2, 1, 0, 0, 0, 2, 8'h13, 23'd6};
        vecs[3] = '{32'h0000_5000, 23'd0,  1, 4'h7, 0, -1, 0, 1, 0, 0, 8'h17, 23'd0};
        vecs[4] = '{32'h0000_6000, 23'd8,  1, 4'h1, 2, -1, 0, 0, 3, 2, 8'h11, 23'd0};
        vecs[5] = '{32'hFFFF_FFF8, 23'd12, 0, 4'hA, 3, -1, 0, 0, 0, 3, 8'h8A, 23'd0};
        vecs[6] = '{32'h0000_7000, 23'd4,  0, 4'h2, 1, 0, 0, 0, 0, 1, 8'h12, 23'd0};
        vecs[7] = '{32'h0000_8000, 23'd6,  1, 4'h9, 0, -1, 0, 1, 0, 0, 8'h19, 23'd1};

        rst = 1'b1;
        bus.S_AXIS_CMD_TVALID  = 1'b0;
        bus.S_AXIS_CMD_TDATA   = '0;
        bus.M_AXIS_STS_TREADY  = 1'b0;
        bus.S_AXIS_DATA_TVALID = 1'b0;
        bus.S_AXIS_DATA_TLAST  = 1'b0;
        bus.S_AXIS_DATA_TDATA  = '0;
        bus.mem_wr_ready       = 1'b1;

        #1;
        chk_outputs_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_outputs_zero("reset_clk");
        rst = 1'b0;
        #1;
        chk("cmd_rdy_before_edge", {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd0);
        @(posedge clk);
        #1;
        chk("cmd_rdy_after_edge", {63'd0, bus.S_AXIS_CMD_TREADY}, 64'd1);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset in the middle of a 4-beat transfer, right after beat 1.
        wq_addr.delete();
        wq_data.delete();
        wait_cmd_ready();
        send_cmd(32'h0000_3000, 23'd16, 1'b1, 4'h4);
        bus.S_AXIS_DATA_TVALID = 1'b1;
        bus.S_AXIS_DATA_TDATA  = pat(4'h4, 0);
        bus.S_AXIS_DATA_TLAST  = 1'b0;
        bus.mem_wr_ready       = 1'b1;
        @(posedge clk);
        #1;
        bus.S_AXIS_DATA_TDATA = pat(4'h4, 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midxfer_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk_outputs_zero("midxfer_rst_held");
        nw = wq_addr.size();
        chk("midxfer_nwrites", 64'(nw), 64'd1);
        bus.S_AXIS_DATA_TVALID = 1'b0;
        rst = 1'b0;
        cnt_model = 0;
        @(posedge clk);
        #1;
        chk("midxfer_no_sts", {63'd0, bus.M_AXIS_STS_TVALID}, 64'd0);
        chk("midxfer_idle", {62'd0, bus.debug[1:0]}, 64'd0);
        rv = vecs[0];
        rv.addr = 32'h0000_4000;
        rv.tag  = 4'h6;
        rv.exp_sts = 8'h86;
        run_vec(rv, "after_rst");
        chk("after_rst_cnt_is_1", {48'd0, bus.debug[40:25]}, 64'd1);

        // Reset while status is pending: status must vanish and not count.
        wait_cmd_ready();
        send_cmd(32'h0000_9000, 23'd0, 1'b0, 4'hC);
        chk("midsts_sts_v", {63'd0, bus.M_AXIS_STS_TVALID}, 64'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midsts_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midsts_no_sts", {63'd0, bus.M_AXIS_STS_TVALID}, 64'd0);
        chk("midsts_cnt", {48'd0, bus.debug[40:25]}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
